semaphore_bank: RTL and testbench

SEMAPHORE_BANK -- requirements
Module: semaphore_bank

---
 rtl/semaphore_bank.sv | 145 ++++++++++++++
 tb/tb_semaphore_bank.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/semaphore_bank.sv
// rtl/semaphore_bank.sv - bank of binary semaphores shared by several cores with round-robin contention
module semaphore_bank #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NumberOfCores-1:0]                    SEMAPHOREBANK_ReqValid_fromCPU,
  input  logic [NumberOfCores-1:0]                    SEMAPHOREBANK_ReqOp_fromCPU,
  input  logic [8*NumberOfCores-1:0]                  SEMAPHOREBANK_ReqAddr_fromCPU,
  output logic [NumberOfCores-1:0]                    SEMAPHOREBANK_Ack_toCPU,
  output logic [NumberOfCores-1:0]                    SEMAPHOREBANK_Denied_toCPU,
  output logic [NumberOfCores-1:0]                    SEMAPHOREBANK_Err_toCPU,
  output logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHOREBANK_Blocking_toMux,
  output logic [NumberOfSemaphores-1:0]               SEMAPHOREBANK_Held_toCPU
);

  localparam int NS = NumberOfSemaphores;
  localparam int NC = NumberOfCores;
  localparam int OW = (NC > 1) ? $clog2(NC) : 1;

  if (NS * NC > 256 || NS < 1 || NC < 1) begin : g_bad_params
    $error("semaphore_bank: NumberOfSemaphores*NumberOfCores must be in 1..256");
  end

  logic [NS-1:0] held_q, held_d;
  logic [OW-1:0] owner_q [NS];
  logic [OW-1:0] owner_d [NS];
  logic [OW-1:0] ptr_q   [NS];
  logic [OW-1:0] ptr_d   [NS];
  logic [NC-1:0] ack_q, ack_d, den_q, den_d, err_q, err_d;
  logic [7:0]    addr_c  [NC];

  for (genvar c = 0; c < NC; c++) begin : g_addr
    assign addr_c[c] = SEMAPHOREBANK_ReqAddr_fromCPU[8*c +: 8];
  end

  // Resolve every request: range check, releases first, then acquires on post-release state
  always_comb begin
    logic [NC-1:0] acq;
    logic          post_held;
    logic          found;
    int            win;
    int            idx;
    acq       = '0;
    post_held = 1'b0;
    found     = 1'b0;
    win       = 0;
    idx       = 0;
    held_d    = held_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    ack_d     = '0;
    den_d     = '0;
    err_d     = '0;

    for (int c = 0; c < NC; c++) begin
      if (SEMAPHOREBANK_ReqValid_fromCPU[c] && ({24'd0, addr_c[c]} >= 32'(NS))) begin
        err_d[c] = 1'b1;
      end
    end

    for (int s = 0; s < NS; s++) begin
      acq       = '0;
      post_held = held_q[s];
      for (int c = 0; c < NC; c++) begin
        if (SEMAPHOREBANK_ReqValid_fromCPU[c] && addr_c[c] == 8'(s)) begin
          if (!SEMAPHOREBANK_ReqOp_fromCPU[c]) begin
            if (held_q[s] && owner_q[s] == OW'(c)) begin
              ack_d[c]  = 1'b1;
              post_held = 1'b0;
            end else begin
              err_d[c] = 1'b1;
            end
          end else begin
            acq[c] = 1'b1;
          end
        end
      end
      held_d[s] = post_held;

      if (post_held) begin
        // Still held after releases: only the owner is acknowledged, without any change
        for (int c = 0; c < NC; c++) begin
          if (acq[c]) begin
            if (owner_q[s] == OW'(c)) ack_d[c] = 1'b1;
            else                      den_d[c] = 1'b1;
          end
        end
      end else if (acq != '0) begin
        found = 1'b0;
        win   = 0;
        for (int k = 1; k <= NC; k++) begin
          idx = (int'(ptr_q[s]) + k) % NC;
          if (!found && acq[idx]) begin
            win   = idx;
            found = 1'b1;
          end
        end
        held_d[s]  = 1'b1;
        owner_d[s] = OW'(win);
        if ($countones(acq) > 1) ptr_d[s] = OW'(win);
        for (int c = 0; c < NC; c++) begin
          if (acq[c]) begin
            if (c == win) ack_d[c] = 1'b1;
            else          den_d[c] = 1'b1;
          end
        end
      end
    end
  end

  // State and one-cycle response registers; reset frees every semaphore and drops requests
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= '0;
      ack_q  <= '0;
      den_q  <= '0;
      err_q  <= '0;
      for (int s = 0; s < NS; s++) begin
        owner_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      held_q  <= held_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      den_q   <= den_d;
      err_q   <= err_d;
    end
  end

  assign SEMAPHOREBANK_Ack_toCPU    = ack_q;
  assign SEMAPHOREBANK_Denied_toCPU = den_q;
  assign SEMAPHOREBANK_Err_toCPU    = err_q;
  assign SEMAPHOREBANK_Held_toCPU   = held_q;

  for (genvar s = 0; s < NS; s++) begin : g_blk_s
    for (genvar c = 0; c < NC; c++) begin : g_blk_c
      assign SEMAPHOREBANK_Blocking_toMux[s*NC+c] = held_q[s] && (owner_q[s] != OW'(c));
    end
  end

endmodule

// File: tb/tb_semaphore_bank.sv
// tb/tb_semaphore_bank.sv - directed self-checking bench for semaphore_bank
module tb_semaphore_bank;
  logic        clk;
  logic        rst;
  logic [1:0]  valid;
  logic [1:0]  op;
  logic [15:0] addr;
  logic [1:0]  ack, den, err;
  logic [7:0]  blocking;
  logic [3:0]  held;
  int          tests;
  int          failed;

  semaphore_bank #(.NumberOfSemaphores(4), .NumberOfCores(2)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .SEMAPHOREBANK_ReqValid_fromCPU (valid),
    .SEMAPHOREBANK_ReqOp_fromCPU    (op),
    .SEMAPHOREBANK_ReqAddr_fromCPU  (addr),
    .SEMAPHOREBANK_Ack_toCPU        (ack),
    .SEMAPHOREBANK_Denied_toCPU     (den),
    .SEMAPHOREBANK_Err_toCPU        (err),
    .SEMAPHOREBANK_Blocking_toMux   (blocking),
    .SEMAPHOREBANK_Held_toCPU       (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] o, input logic [7:0] a1, input logic [7:0] a0);
    valid = v;
    op    = o;
    addr  = {a1, a0};
    @(posedge clk);
    #1;
    valid = 2'b00;
    op    = 2'b00;
    addr  = 16'd0;
  endtask

  task automatic resp(input string tag, input logic [1:0] a, input logic [1:0] d, input logic [1:0] e);
    chk({tag, "_ack"}, {30'd0, ack}, {30'd0, a});
    chk({tag, "_den"}, {30'd0, den}, {30'd0, d});
    chk({tag, "_err"}, {30'd0, err}, {30'd0, e});
  endtask

  task automatic state(input string tag, input logic [3:0] h, input logic [7:0] b);
    chk({tag, "_held"}, {28'd0, held}, {28'd0, h});
    chk({tag, "_blk"},  {24'd0, blocking}, {24'd0, b});
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    valid  = 2'b00;
    op     = 2'b00;
    addr   = 16'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    resp("reset", 2'b00, 2'b00, 2'b00);
    state("reset", 4'b0000, 8'h00);

    // core0 acquires sem2
    step(2'b01, 2'b01, 8'd0, 8'd2);
    resp("acq0_s2", 2'b01, 2'b00, 2'b00);
    state("acq0_s2", 4'b0100, 8'b0010_0000);

    // responses last one cycle only
    step(2'b00, 2'b00, 8'd0, 8'd0);
    resp("idle", 2'b00, 2'b00, 2'b00);

    // core1 acquires held sem2 -> denied
    step(2'b10, 2'b10, 8'd2, 8'd0);
    resp("acq1_s2_held", 2'b00, 2'b10, 2'b00);
    state("acq1_s2_held", 4'b0100, 8'b0010_0000);

    // owner re-acquires -> idempotent ack
    step(2'b01, 2'b01, 8'd0, 8'd2);
    resp("reacq0_s2", 2'b01, 2'b00, 2'b00);
    state("reacq0_s2", 4'b0100, 8'b0010_0000);

    // core0 releases sem2
    step(2'b01, 2'b00, 8'd0, 8'd2);
    resp("rel0_s2", 2'b01, 2'b00, 2'b00);
    state("rel0_s2", 4'b0000, 8'h00);

    // contest on sem1, pointer 0 -> core1 wins
    step(2'b11, 2'b11, 8'd1, 8'd1);
    resp("contest1", 2'b10, 2'b01, 2'b00);
    state("contest1", 4'b0010, 8'b0000_0100);
    step(2'b10, 2'b00, 8'd1, 8'd0);
    resp("rel1_s1", 2'b10, 2'b00, 2'b00);
    state("rel1_s1", 4'b0000, 8'h00);

    // contest again, pointer 1 -> core0 wins
    step(2'b11, 2'b11, 8'd1, 8'd1);
    resp("contest2", 2'b01, 2'b10, 2'b00);
    state("contest2", 4'b0010, 8'b0000_1000);
    step(2'b01, 2'b00, 8'd0, 8'd1);
    resp("rel0_s1", 2'b01, 2'b00, 2'b00);

    // uncontested grant to core1 must leave pointer at 0
    step(2'b10, 2'b10, 8'd1, 8'd0);
    resp("uncont1_s1", 2'b10, 2'b00, 2'b00);
    step(2'b10, 2'b00, 8'd1, 8'd0);
    resp("uncont_rel", 2'b10, 2'b00, 2'b00);
    step(2'b11, 2'b11, 8'd1, 8'd1);
    resp("contest3", 2'b10, 2'b01, 2'b00);
    step(2'b10, 2'b00, 8'd1, 8'd0);
    resp("rel1_s1b", 2'b10, 2'b00, 2'b00);
    state("rel1_s1b", 4'b0000, 8'h00);

    // release-before-acquire handoff of sem3
    step(2'b01, 2'b01, 8'd0, 8'd3);
    resp("acq0_s3", 2'b01, 2'b00, 2'b00);
    step(2'b11, 2'b10, 8'd3, 8'd3);
    resp("handoff_s3", 2'b11, 2'b00, 2'b00);
    state("handoff_s3", 4'b1000, 8'b0100_0000);

    // out-of-range index and release of a free semaphore
    step(2'b11, 2'b10, 8'd7, 8'd0);
    resp("err_range_free", 2'b00, 2'b00, 2'b11);
    state("err_range_free", 4'b1000, 8'b0100_0000);

    // release by non-owner
    step(2'b01, 2'b00, 8'd0, 8'd3);
    resp("err_nonowner", 2'b00, 2'b00, 2'b01);
    state("err_nonowner", 4'b1000, 8'b0100_0000);

    // independent semaphores in the same cycle
    step(2'b11, 2'b11, 8'd1, 8'd0);
    resp("indep", 2'b11, 2'b00, 2'b00);
    state("indep", 4'b1011, 8'b0100_0110);

    // reset mid-ownership with a request in the reset cycle
    rst = 1'b1;
    step(2'b01, 2'b01, 8'd0, 8'd2);
    rst = 1'b0;
    resp("rst_mid", 2'b00, 2'b00, 2'b00);
    state("rst_mid", 4'b0000, 8'h00);
    step(2'b00, 2'b00, 8'd0, 8'd0);
    resp("rst_after", 2'b00, 2'b00, 2'b00);
    state("rst_after", 4'b0000, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
